phy_tx_lane_sched: RTL and testbench

Byte-slot scheduler in front of the PHY TX serializer path. It shares the single clk4f byte slot between four 8-bit lane sources (in0..in3 / validmux41) using a round-robin arbiter with a per-lane grant handshake. It sequences link bring-up by emitting COM training symbols after in_rx_tx rises, then fills empty slots with COM idle symbols. It drives a registered byte stream with a K-char flag toward the par-to-serial stage.

---
 rtl/phy_tx_lane_sched.sv | 123 ++++++++++++
 tb/tb_phy_tx_lane_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lane_sched.sv
// phy_tx_lane_sched: round-robin byte-slot scheduler for four TX lanes with COM training/idle fill.
// Optional SKP ordered-symbol insertion is enabled by defining PHY_TX_SKP_INSERT_EN.
module phy_tx_lane_sched #(
    parameter int unsigned SYNC_COUNT   = 4,
    parameter logic [7:0]  IDLE_SYM     = 8'hBC,
    parameter logic [7:0]  SKP_SYM      = 8'h1C,
    parameter int unsigned SKP_INTERVAL = 64
) (
    input  logic       clk4f,
    input  logic       reset,
    input  logic       in_rx_tx,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] validmux41,
    output logic [3:0] grant,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_k,
    output logic [1:0] out_lane,
    output logic [1:0] sched_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRAIN = 2'd1, S_ACTIVE = 2'd2} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt, w_win, r_lane, w_lane_nxt;
    logic [7:0] r_cnt, w_cnt_nxt, r_data, w_data_nxt, w_lane_data;
    logic       r_valid, w_valid_nxt, r_k, w_k_nxt, w_found, w_skp, w_serve;

    // First valid lane at or after the pointer wins; loop runs downward so the lowest offset overrides.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int j = 3; j >= 0; j--) begin
            if (validmux41[r_ptr + 2'(j)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(j);
            end
        end
    end

    assign w_lane_data = (w_win == 2'd0) ? in0 : (w_win == 2'd1) ? in1 : (w_win == 2'd2) ? in2 : in3;
    assign w_serve     = (r_state == S_ACTIVE) && in_rx_tx && !w_skp && w_found;
    assign grant       = w_serve ? (4'b0001 << w_win) : 4'd0;

`ifdef PHY_TX_SKP_INSERT_EN
    localparam int SW = $clog2(SKP_INTERVAL);
    logic [SW-1:0] r_slot;
    assign w_skp = (r_state == S_ACTIVE) && (r_slot == SW'(SKP_INTERVAL - 1));
    always_ff @(posedge clk4f or posedge reset) begin
        if (reset)
            r_slot <= '0;
        else if (r_state == S_ACTIVE && in_rx_tx)
            r_slot <= w_skp ? '0 : r_slot + 1'b1;
        else
            r_slot <= '0;
    end
`else
    // SKP_INTERVAL is always >= 2, so no slot is ever a SKP slot in this build.
    assign w_skp = (SKP_INTERVAL == 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = IDLE_SYM;
        w_k_nxt     = 1'b1;
        w_valid_nxt = 1'b0;
        w_lane_nxt  = r_lane;
        if (!in_rx_tx) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_TRAIN;
                    w_cnt_nxt   = 8'd0;
                end
                S_TRAIN: begin
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_state_nxt = (r_cnt == 8'(SYNC_COUNT - 1)) ? S_ACTIVE : S_TRAIN;
                end
                S_ACTIVE: begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_skp ? SKP_SYM : w_serve ? w_lane_data : IDLE_SYM;
                    w_k_nxt     = !w_serve;
                    w_lane_nxt  = w_serve ? w_win : r_lane;
                    w_ptr_nxt   = w_serve ? w_win + 2'd1 : r_ptr;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk4f or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= 8'd0;
            r_data  <= IDLE_SYM;
            r_valid <= 1'b0;
            r_k     <= 1'b1;
            r_lane  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_k     <= w_k_nxt;
            r_lane  <= w_lane_nxt;
        end
    end

    assign out_data    = r_data;
    assign out_valid   = r_valid;
    assign out_k       = r_k;
    assign out_lane    = r_lane;
    assign sched_state = r_state;
endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// tb_phy_tx_lane_sched: directed vector table, async-reset sequences and random run against a slot-level model.
module tb_phy_tx_lane_sched;
    localparam int SYNC = 4;

    logic       clk4f = 1'b0;
    logic       reset;
    logic       in_rx_tx;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] validmux41;
    logic [3:0] grant;
    logic [7:0] out_data;
    logic       out_valid, out_k;
    logic [1:0] out_lane, sched_state;

    int n_tests = 0;
    int n_fail  = 0;

    phy_tx_lane_sched dut (
        .clk4f(clk4f), .reset(reset), .in_rx_tx(in_rx_tx),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .validmux41(validmux41),
        .grant(grant), .out_data(out_data), .out_valid(out_valid), .out_k(out_k),
        .out_lane(out_lane), .sched_state(sched_state)
    );

    always #5 clk4f = ~clk4f;

    typedef struct {
        logic       rx;
        logic [3:0] vm;
        logic [7:0] d2;
        logic [3:0] g;
        logic [7:0] data;
        logic       v;
        logic       k;
        logic [1:0] lane;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    // Slot-level reference: what the link should be doing, tracked as plain integers.
    int         m_st, m_ptr, m_cnt, m_lane;
    logic [7:0] m_data;
    logic       m_v, m_k;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ptr = 0; m_cnt = 0; m_lane = 0;
        m_data = 8'hBC; m_v = 1'b0; m_k = 1'b1;
    endtask

    function automatic int model_pick();
        int l;
        if (m_st != 2 || !in_rx_tx) return -1;
        for (int o = 0; o < 4; o++) begin
            l = (m_ptr + o) % 4;
            if (validmux41[l]) return l;
        end
        return -1;
    endfunction

    function automatic logic [7:0] lane_byte(input int l);
        return (l == 0) ? in0 : (l == 1) ? in1 : (l == 2) ? in2 : in3;
    endfunction

    task automatic model_step(input int w);
        if (!in_rx_tx) begin
            m_st = 0; m_ptr = 0; m_data = 8'hBC; m_k = 1'b1; m_v = 1'b0;
        end else if (m_st == 0) begin
            m_st = 1; m_cnt = 0; m_data = 8'hBC; m_k = 1'b1; m_v = 1'b0;
        end else if (m_st == 1) begin
            m_data = 8'hBC; m_k = 1'b1; m_v = 1'b1; m_cnt++;
            if (m_cnt == SYNC) m_st = 2;
        end else begin
            m_v = 1'b1;
            if (w >= 0) begin
                m_data = lane_byte(w); m_k = 1'b0; m_lane = w; m_ptr = (w + 1) % 4;
            end else begin
                m_data = 8'hBC; m_k = 1'b1;
            end
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic k,
                           input logic [1:0] l, input logic [1:0] s);
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".k"}, out_k, k);
        chk({tag, ".lane"}, out_lane, l);
        chk({tag, ".state"}, sched_state, s);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_out(tag, 8'hBC, 1'b0, 1'b1, 2'd0, 2'd0);
        chk({tag, ".grant"}, grant, 4'h0);
    endtask

    // Called at posedge+1; pulses reset mid-cycle and re-aligns at the next posedge+1.
    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1 chk_reset_vals(tag);
        model_reset();
        #3 reset = 1'b0;
        model_step(model_pick());
        @(posedge clk4f); #1;
        chk_out({tag, ".post"}, m_data, m_v, m_k, 2'(m_lane), 2'(m_st));
    endtask

    task automatic add(input logic rx, input logic [3:0] vm, input logic [7:0] d2, input logic [3:0] g,
                       input logic [7:0] data, input logic v, input logic k, input logic [1:0] lane,
                       input logic [1:0] st);
        vec_t r;
        r.rx = rx; r.vm = vm; r.d2 = d2; r.g = g; r.data = data; r.v = v; r.k = k; r.lane = lane; r.st = st;
        tbl.push_back(r);
    endtask

    initial begin
        add(0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 1, 0, 0);
        add(1, 4'h0, 8'h33, 4'h0, 8'hBC, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 4'h0, 8'h33, 4'h0, 8'hBC, 1, 1, 0, 1);
        add(1, 4'h0, 8'h33, 4'h0, 8'hBC, 1, 1, 0, 2);
        add(1, 4'h0, 8'h33, 4'h0, 8'hBC, 1, 1, 0, 2);
        add(1, 4'hF, 8'h33, 4'h1, 8'h11, 1, 0, 0, 2);
        add(1, 4'hF, 8'h33, 4'h2, 8'h22, 1, 0, 1, 2);
        add(1, 4'hF, 8'h33, 4'h4, 8'h33, 1, 0, 2, 2);
        add(1, 4'hF, 8'h33, 4'h8, 8'h44, 1, 0, 3, 2);
        add(1, 4'hF, 8'h33, 4'h1, 8'h11, 1, 0, 0, 2);
        add(1, 4'hA, 8'h33, 4'h2, 8'h22, 1, 0, 1, 2);
        add(1, 4'hA, 8'h33, 4'h8, 8'h44, 1, 0, 3, 2);
        add(1, 4'hA, 8'h33, 4'h2, 8'h22, 1, 0, 1, 2);
        add(1, 4'hA, 8'h33, 4'h8, 8'h44, 1, 0, 3, 2);
        add(1, 4'h1, 8'h33, 4'h1, 8'h11, 1, 0, 0, 2);
        add(1, 4'h0, 8'h33, 4'h0, 8'hBC, 1, 1, 0, 2);
        add(0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 1, 0, 0);
        add(1, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 4'hF, 8'h33, 4'h0, 8'hBC, 1, 1, 0, 1);
        add(1, 4'hF, 8'h33, 4'h0, 8'hBC, 1, 1, 0, 2);
        add(1, 4'hF, 8'h33, 4'h1, 8'h11, 1, 0, 0, 2);
        add(1, 4'h4, 8'hBC, 4'h4, 8'hBC, 1, 0, 2, 2);

        reset = 1'b1; in_rx_tx = 1'b0; validmux41 = 4'hF;
        in0 = 8'h11; in1 = 8'h22; in2 = 8'h33; in3 = 8'h44;
        #3 chk_reset_vals("rst0");
        #9 chk_reset_vals("rst1");
        @(posedge clk4f); #1;
        chk_reset_vals("rst2");
        reset = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            in_rx_tx = tbl[i].rx; validmux41 = tbl[i].vm; in2 = tbl[i].d2;
            @(negedge clk4f);
            chk($sformatf("vec%0d.grant", i), grant, tbl[i].g);
            model_step(model_pick());
            @(posedge clk4f); #1;
            chk_out($sformatf("vec%0d", i), tbl[i].data, tbl[i].v, tbl[i].k, tbl[i].lane, tbl[i].st);
        end

        in2 = 8'h33; validmux41 = 4'hF;
        async_reset_pulse("mid_active_rst");

        for (int c = 0; c < 600; c++) begin
            int w;
            if ($urandom_range(0, 149) == 0) begin
                async_reset_pulse("rand_rst");
                continue;
            end
            in_rx_tx = ($urandom_range(0, 29) != 0);
            validmux41 = 4'($urandom);
            in0 = ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom);
            in1 = ($urandom_range(0, 7) == 0) ? 8'h1C : 8'($urandom);
            in2 = 8'($urandom);
            in3 = 8'($urandom);
            @(negedge clk4f);
            w = model_pick();
            chk("rand.grant", grant, (w >= 0) ? (4'b0001 << w) : 4'h0);
            model_step(w);
            @(posedge clk4f); #1;
            chk_out("rand", m_data, m_v, m_k, 2'(m_lane), 2'(m_st));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
